mem_arbiter: RTL and testbench

- Arbitrates the shared byte-addressed data memory between two requesters: instruction fetch (port IF, word reads only) and load/store unit (port LS, byte/half/word reads and writes).
- Drives the memory's enable/write/read access vector, size, address and write data; collects the memory's one-cycle registered read data.
- Enforces alignment, applies fixed LS priority with a fetch anti-starvation counter, and returns one response per transaction.

---
 rtl/mem_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-addressed data memory between instruction
// fetch (IF, word reads) and the load/store unit (LS, byte/half/word).
// Every transaction runs IDLE -> ISSUE -> WAIT -> RESP. Misaligned or
// illegal requests skip straight from IDLE to RESP without touching memory.
// LS has fixed priority, except that IF wins once it has lost
// STARVE_LIMIT arbitrations in a row.
module mem_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [1:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [2:0]        mem_access,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              win_if_q, win_if_d;  // latched winner: 1 = IF, 0 = LS
  logic              we_q, we_d;          // latched direction of the winner

  logic              if_gnt_q, if_gnt_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              ls_gnt_q, ls_gnt_d;
  logic              ls_rvalid_q, ls_rvalid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [2:0]        mem_access_q, mem_access_d;
  logic [1:0]        mem_size_q, mem_size_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  // Fields of the request selected in IDLE.
  logic              sel_if;
  logic              sel_we;
  logic [1:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic              sel_err;

  // Arbitration, alignment check, next state and next registered outputs.
  always_comb begin
    // NOTE: every variable gets a default before the case statement, so no
    // path leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    cnt_d        = cnt_q;
    win_if_d     = win_if_q;
    we_d         = we_q;
    if_gnt_d     = 1'b0;
    if_rvalid_d  = 1'b0;
    ls_gnt_d     = 1'b0;
    ls_rvalid_d  = 1'b0;
    rsp_rdata_d  = '0;
    rsp_err_d    = 1'b0;
    mem_access_d = 3'b000;
    mem_size_d   = mem_size_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    sel_if       = 1'b0;
    sel_we       = 1'b0;
    sel_size     = SZ_WORD;
    sel_addr     = '0;
    sel_wdata    = '0;
    sel_err      = 1'b0;

    case (state_q)
      IDLE: begin
        if (if_req || ls_req) begin
          sel_if = if_req && (!ls_req || cnt_q == LIMIT);
          if (sel_if) begin
            sel_we    = 1'b0;
            sel_size  = SZ_WORD;
            sel_addr  = if_addr;
            sel_wdata = '0;
            cnt_d     = '0;
          end else begin
            sel_we    = ls_we;
            sel_size  = ls_size;
            sel_addr  = ls_addr;
            sel_wdata = ls_wdata;
            // IF lost this round; it cannot be at the limit here.
            if (if_req) cnt_d = cnt_q + 1'b1;
          end

          sel_err = (sel_size == SZ_ILL)
                 || (sel_size == SZ_HALF && sel_addr[0])
                 || (sel_size == SZ_WORD && sel_addr[1:0] != 2'b00);

          win_if_d = sel_if;
          we_d     = sel_we;
          if_gnt_d = sel_if;
          ls_gnt_d = !sel_if;

          if (sel_err) begin
            // Reject without a memory access: grant and response together.
            rsp_err_d   = 1'b1;
            if_rvalid_d = sel_if;
            ls_rvalid_d = !sel_if;
            state_d     = RESP;
          end else begin
            mem_access_d = {~sel_we, sel_we, 1'b1};
            mem_size_d   = sel_size;
            mem_addr_d   = sel_addr;
            mem_wdata_d  = sel_wdata;
            state_d      = ISSUE;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // Memory returns read data one cycle after the command.
        rsp_rdata_d = we_q ? 32'h0 : mem_rdata;
        if_rvalid_d = win_if_q;
        ls_rvalid_d = !win_if_q;
        state_d     = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Unused with SZ_BYTE; kept so all encodings are named.
    if (sel_size == SZ_BYTE) sel_err = 1'b0;
  end

  // State, latched transaction fields and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      win_if_q     <= 1'b0;
      we_q         <= 1'b0;
      if_gnt_q     <= 1'b0;
      if_rvalid_q  <= 1'b0;
      ls_gnt_q     <= 1'b0;
      ls_rvalid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      mem_access_q <= 3'b000;
      mem_size_q   <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values of
      // the previous cycle, independent of statement order.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      win_if_q     <= win_if_d;
      we_q         <= we_d;
      if_gnt_q     <= if_gnt_d;
      if_rvalid_q  <= if_rvalid_d;
      ls_gnt_q     <= ls_gnt_d;
      ls_rvalid_q  <= ls_rvalid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      mem_access_q <= mem_access_d;
      mem_size_q   <= mem_size_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign if_gnt     = if_gnt_q;
  assign if_rvalid  = if_rvalid_q;
  assign ls_gnt     = ls_gnt_q;
  assign ls_rvalid  = ls_rvalid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign mem_access = mem_access_q;
  assign mem_size   = mem_size_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives both requesters against mem_arbiter connected to a
// behavioural 1 KiB memory, and predicts winner, timing, error and read data
// from a transaction-level model (shadow byte array + loss counter).
module tb_mem_arbiter;

  localparam int ADDR_W = 10;
  localparam int LIMIT  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              if_req, if_gnt, if_rvalid;
  logic [ADDR_W-1:0] if_addr;
  logic              ls_req, ls_we, ls_gnt, ls_rvalid;
  logic [1:0]        ls_size;
  logic [ADDR_W-1:0] ls_addr;
  logic [31:0]       ls_wdata;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [2:0]        mem_access;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = 32'h0;

  mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_access(mem_access), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory: little-endian, sign-extending byte/half reads, data next cycle.
  logic [7:0] dev_mem [0:1023];
  logic [7:0] ref_mem [0:1023];

  function automatic logic [31:0] load_val(input logic [1:0] sz, input logic [7:0] b0,
                                           input logic [7:0] b1, input logic [7:0] b2,
                                           input logic [7:0] b3);
    case (sz)
      2'b00:   return {{24{b0[7]}}, b0};
      2'b01:   return {{16{b1[7]}}, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  always @(posedge clk) begin
    logic [9:0] a0, a1, a2, a3;
    a0 = mem_addr; a1 = a0 + 10'd1; a2 = a0 + 10'd2; a3 = a0 + 10'd3;
    if (mem_access[0]) begin
      if (mem_access[1]) begin
        dev_mem[a0] <= mem_wdata[7:0];
        if (mem_size != 2'b00) dev_mem[a1] <= mem_wdata[15:8];
        if (mem_size == 2'b10) begin
          dev_mem[a2] <= mem_wdata[23:16];
          dev_mem[a3] <= mem_wdata[31:24];
        end
      end
      if (mem_access[2])
        mem_rdata <= load_val(mem_size, dev_mem[a0], dev_mem[a1], dev_mem[a2], dev_mem[a3]);
    end
  end

  // Pending requests, model state and bookkeeping.
  bit          if_pend, ls_pend, ls_w;
  logic [9:0]  if_a, ls_a;
  logic [1:0]  ls_sz;
  logic [31:0] ls_d;
  int          losses;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          obs_win;           // 0 none, 1 IF, 2 LS, 3 both
  logic [31:0] obs_rdata;
  logic        obs_err;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0; ls_size = 0; ls_addr = '0; ls_wdata = 0;
    if_pend = 0; ls_pend = 0; losses = 0;
    step; step;
    rst_n = 1'b1;
  endtask

  // One arbitration slot starting in an IDLE cycle; returns in the next IDLE cycle.
  task automatic run_slot;
    bit          w_if, err, we;
    logic [1:0]  sz;
    logic [9:0]  a, a1, a2, a3;
    logic [31:0] wd, exp_rd;
    if_req = if_pend; if_addr = if_a;
    ls_req = ls_pend; ls_we = ls_w; ls_size = ls_sz; ls_addr = ls_a; ls_wdata = ls_d;
    obs_win = 0;
    if (!if_pend && !ls_pend) begin
      step;
      n_checks++;
      if ({if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_access} !== 7'b0) begin
        n_fail++;
        $display("FAIL idle_quiet: got %b expected 0", {if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_access});
      end
      return;
    end

    w_if = if_pend && (!ls_pend || losses == LIMIT);
    if (w_if) begin
      losses = 0; we = 0; sz = 2'b10; a = if_a; wd = 0;
    end else begin
      if (if_pend && losses < LIMIT) losses++;
      we = ls_w; sz = ls_sz; a = ls_a; wd = ls_d;
    end
    err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    a1 = a + 10'd1; a2 = a + 10'd2; a3 = a + 10'd3;
    exp_rd = 32'h0;
    if (!err && !we) exp_rd = load_val(sz, ref_mem[a], ref_mem[a1], ref_mem[a2], ref_mem[a3]);
    if (!err && we) begin
      ref_mem[a] = wd[7:0];
      if (sz != 2'b00) ref_mem[a1] = wd[15:8];
      if (sz == 2'b10) begin ref_mem[a2] = wd[23:16]; ref_mem[a3] = wd[31:24]; end
    end

    step;  // T+1
    obs_win = {30'b0, ls_gnt, if_gnt};
    n_checks++;
    if ({if_gnt, ls_gnt} !== {w_if, !w_if}) begin
      n_fail++;
      $display("FAIL gnt: got if/ls=%b expected %b", {if_gnt, ls_gnt}, {w_if, !w_if});
    end
    if (err) begin
      obs_rdata = rsp_rdata; obs_err = rsp_err;
      n_checks++;
      if ({if_rvalid, ls_rvalid, rsp_err, rsp_rdata, mem_access} !== {w_if, !w_if, 1'b1, 32'h0, 3'b000}) begin
        n_fail++;
        $display("FAIL err_resp: got rv=%b err=%b rdata=%h acc=%b expected rv=%b err=1 rdata=0 acc=000",
                 {if_rvalid, ls_rvalid}, rsp_err, rsp_rdata, mem_access, {w_if, !w_if});
      end
    end else begin
      n_checks++;
      if ({if_rvalid, ls_rvalid, mem_access, mem_size, mem_addr} !== {2'b00, ~we, we, 1'b1, sz, a}) begin
        n_fail++;
        $display("FAIL issue: got rv=%b acc=%b size=%b addr=%h expected rv=00 acc=%b size=%b addr=%h",
                 {if_rvalid, ls_rvalid}, mem_access, mem_size, mem_addr, {~we, we, 1'b1}, sz, a);
      end
      if (we) begin
        n_checks++;
        if (mem_wdata !== wd) begin
          n_fail++;
          $display("FAIL issue_wdata: got %h expected %h", mem_wdata, wd);
        end
      end
    end

    // Winner drops its request; its fields are scrambled to prove latching.
    if (w_if) begin
      if_pend = 0; if_req = 0; if_addr = 10'($urandom);
    end else begin
      ls_pend = 0; ls_req = 0; ls_addr = 10'($urandom); ls_wdata = $urandom;
      ls_we = 1'($urandom); ls_size = 2'($urandom);
    end

    step;  // T+2
    n_checks++;
    if ({if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_access} !== 7'b0) begin
      n_fail++;
      $display("FAIL t2_quiet: got gnt=%b rv=%b acc=%b expected all 0",
               {if_gnt, ls_gnt}, {if_rvalid, ls_rvalid}, mem_access);
    end
    if (err) return;

    step;  // T+3
    obs_rdata = rsp_rdata; obs_err = rsp_err;
    n_checks++;
    if ({if_gnt, ls_gnt, if_rvalid, ls_rvalid, rsp_err, rsp_rdata} !== {2'b00, w_if, !w_if, 1'b0, exp_rd}) begin
      n_fail++;
      $display("FAIL resp: got gnt=%b rv=%b err=%b rdata=%h expected gnt=00 rv=%b err=0 rdata=%h",
               {if_gnt, ls_gnt}, {if_rvalid, ls_rvalid}, rsp_err, rsp_rdata, {w_if, !w_if}, exp_rd);
    end

    step;  // T+4, back in IDLE
    n_checks++;
    if ({if_rvalid, ls_rvalid} !== 2'b00) begin
      n_fail++;
      $display("FAIL rvalid_pulse: got %b expected 00", {if_rvalid, ls_rvalid});
    end
  endtask

  task automatic set_ls(input bit w, input logic [1:0] sz, input logic [9:0] a, input logic [31:0] d);
    ls_pend = 1; ls_w = w; ls_sz = sz; ls_a = a; ls_d = d;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    n_checks++;
    if ({if_gnt, if_rvalid, ls_gnt, ls_rvalid, rsp_err, rsp_rdata, mem_access, mem_size, mem_addr, mem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got acc=%b addr=%h rdata=%h expected all 0", mem_access, mem_addr, rsp_rdata);
    end
    apply_reset;
  endtask

  task automatic test_ls_store_load;
    set_ls(1, 2'b10, 10'h010, 32'hDEADBEEF); run_slot;
    set_ls(0, 2'b10, 10'h010, 32'h0);        run_slot;
    n_checks++;
    if (obs_rdata !== 32'hDEADBEEF || obs_err !== 1'b0) begin
      n_fail++;
      $display("FAIL store_load_word: got %h err=%b expected deadbeef err=0", obs_rdata, obs_err);
    end
  endtask

  task automatic test_misaligned;
    set_ls(0, 2'b01, 10'h011, 32'h0); run_slot;
    n_checks++;
    if (obs_err !== 1'b1 || obs_win != 2) begin
      n_fail++;
      $display("FAIL misaligned_half: got err=%b win=%0d expected err=1 win=2", obs_err, obs_win);
    end
    set_ls(1, 2'b11, 10'h000, 32'h5555AAAA); run_slot;
    n_checks++;
    if (obs_err !== 1'b1 || obs_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL illegal_size: got err=%b rdata=%h expected err=1 rdata=0", obs_err, obs_rdata);
    end
  endtask

  task automatic test_if_top;
    set_ls(1, 2'b10, 10'h3FC, 32'h12345678); run_slot;
    if_pend = 1; if_a = 10'h3FC; run_slot;
    n_checks++;
    if (obs_rdata !== 32'h12345678 || obs_win != 1) begin
      n_fail++;
      $display("FAIL if_top_word: got %h win=%0d expected 12345678 win=1", obs_rdata, obs_win);
    end
    if_pend = 1; if_a = 10'h3FE; run_slot;
    n_checks++;
    if (obs_err !== 1'b1 || obs_win != 1) begin
      n_fail++;
      $display("FAIL if_misaligned: got err=%b win=%0d expected err=1 win=1", obs_err, obs_win);
    end
  endtask

  task automatic test_byte_sign;
    set_ls(1, 2'b00, 10'h005, 32'h000000AB); run_slot;
    set_ls(0, 2'b00, 10'h005, 32'h0);        run_slot;
    n_checks++;
    if (obs_rdata !== 32'hFFFFFFAB) begin
      n_fail++;
      $display("FAIL byte_sign: got %h expected ffffffab", obs_rdata);
    end
  endtask

  task automatic test_starvation;
    int exp_pat [10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
    apply_reset;
    for (int i = 0; i < 10; i++) begin
      if (!if_pend) begin if_pend = 1; if_a = 10'h3FC; end
      if (!ls_pend) set_ls(0, 2'b10, 10'h010, 32'h0);
      run_slot;
      n_checks++;
      if (obs_win != exp_pat[i]) begin
        n_fail++;
        $display("FAIL starve_pattern[%0d]: got winner %0d expected %0d", i, obs_win, exp_pat[i]);
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 200; i++) begin
      if (!if_pend && $urandom_range(0, 2) != 0) begin
        if_pend = 1; if_a = 10'h100 + 10'($urandom_range(0, 31));
        if ($urandom_range(0, 7) != 0) if_a[1:0] = 2'b00;
      end
      if (!ls_pend && $urandom_range(0, 2) != 0) begin
        ls_pend = 1; ls_w = 1'($urandom); ls_d = $urandom;
        ls_sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        ls_a = 10'h100 + 10'($urandom_range(0, 31));
        if ($urandom_range(0, 3) != 0) begin
          if (ls_sz == 2'b10) ls_a[1:0] = 2'b00;
          if (ls_sz == 2'b01) ls_a[0] = 1'b0;
        end
      end
      run_slot;
    end
  endtask

  task automatic test_reset_mid;
    apply_reset;
    ls_req = 1; ls_we = 0; ls_size = 2'b10; ls_addr = 10'h010; ls_wdata = 0;
    step;  // ISSUE
    n_checks++;
    if (ls_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_gnt: got %b expected 1", ls_gnt);
    end
    ls_req = 0;
    step;  // WAIT
    if_req = 1; if_addr = 10'h010;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({if_gnt, if_rvalid, ls_gnt, ls_rvalid, rsp_err, rsp_rdata, mem_access, mem_size, mem_addr, mem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_async: got acc=%b size=%b addr=%h expected all 0", mem_access, mem_size, mem_addr);
    end
    for (int i = 0; i < 3; i++) begin
      step;
      n_checks++;
      if ({if_gnt, ls_gnt, if_rvalid, ls_rvalid} !== 4'b0) begin
        n_fail++;
        $display("FAIL mid_reset_hold: got %b expected 0000", {if_gnt, ls_gnt, if_rvalid, ls_rvalid});
      end
    end
    rst_n = 1'b1; losses = 0; ls_pend = 0;
    if_pend = 1; if_a = 10'h010;
    run_slot;
    n_checks++;
    if (obs_win != 1 || obs_rdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL after_reset_if: got win=%0d rdata=%h expected win=1 rdata=deadbeef", obs_win, obs_rdata);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin dev_mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0; ls_size = 0; ls_addr = '0; ls_wdata = 0;
    test_reset;
    test_ls_store_load;
    test_misaligned;
    test_if_top;
    test_byte_sign;
    test_starvation;
    test_random;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
